// File: rtl/cla_pkg.sv
// Shared constants and the block-level carry lookahead used by the pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int MAX_NBLK = 8;

    // Flattened two-level lookahead: every carry is a sum of products of block P/G terms and c0.
    // Unused upper blocks must be passed in as P=0, G=0.
    function automatic logic [MAX_NBLK:0] cla_carries(
        input logic [MAX_NBLK-1:0] p,
        input logic [MAX_NBLK-1:0] g,
        input logic                c0
    );
        logic [MAX_NBLK:0] c;
        logic              run;
        c    = '0;
        c[0] = c0;
        for (int k = 0; k < MAX_NBLK; k++) begin
            run = 1'b1;
            for (int j = k; j >= 0; j--) begin
                c[k+1] = c[k+1] | (g[j] & run);
                run    = run & p[j];
            end
            c[k+1] = c[k+1] | (c0 & run);
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_pg.sv
// One lookahead block: group propagate/generate and both conditional sums for carry-in 0 and 1.
module cla_block_pg
    import cla_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             op_sub,
    output logic             gp,
    output logic             gg,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             msb_c0,
    output logic             msb_c1
);

    logic [BLOCK-1:0] bb;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] x;
    logic [BLOCK-1:0] c0v;
    logic [BLOCK-1:0] c1v;
    logic             run;

    assign bb = b ^ {BLOCK{op_sub}};
    assign p  = a | bb;
    assign g  = a & bb;
    assign x  = a ^ bb;

    // Each bit carry is expanded directly from g/p below it, so no in-block ripple path exists.
    always_comb begin
        c0v = '0;
        c1v = '0;
        gg  = 1'b0;
        gp  = 1'b0;
        run = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            run = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c0v[i] = c0v[i] | (g[j] & run);
                run    = run & p[j];
            end
            c1v[i] = c0v[i] | run;
        end
        run = 1'b1;
        for (int j = BLOCK - 1; j >= 0; j--) begin
            gg  = gg | (g[j] & run);
            run = run & p[j];
        end
        gp = run;
    end

    assign sum0   = x ^ c0v;
    assign sum1   = x ^ c1v;
    assign msb_c0 = c0v[BLOCK-1];
    assign msb_c1 = c1v[BLOCK-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking and status flags.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK = WIDTH / BLOCK;

    generate
        if ((WIDTH % BLOCK) != 0 || NBLK < 1 || NBLK > MAX_NBLK) begin : g_bad_cfg
            $error("cla_addsub_pipe: WIDTH must be a multiple of BLOCK with 1..8 blocks");
        end
    endgenerate

    logic adv1;
    logic adv2;

    logic [NBLK-1:0]  blk_p;
    logic [NBLK-1:0]  blk_g;
    logic [WIDTH-1:0] sum0_w;
    logic [WIDTH-1:0] sum1_w;
    logic [NBLK-1:0]  msb_c0_w;
    logic [NBLK-1:0]  msb_c1_w;

    logic             v1_reg;
    logic [NBLK-1:0]  p1_reg;
    logic [NBLK-1:0]  g1_reg;
    logic [WIDTH-1:0] sum0_reg;
    logic [WIDTH-1:0] sum1_reg;
    logic             cin1_reg;
    logic             msb0_reg;
    logic             msb1_reg;

    logic [MAX_NBLK-1:0] p_ext;
    logic [MAX_NBLK-1:0] g_ext;
    logic [MAX_NBLK:0]   carries;
    logic [WIDTH-1:0]    s_next;
    logic                cout_next;
    logic                ovf_next;
    logic                c_msb;

    logic             v2_reg;
    logic [WIDTH-1:0] s_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             unused_bits;

    assign adv2     = !v2_reg || out_ready;
    assign adv1     = !v1_reg || adv2;
    assign in_ready = adv1;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            cla_block_pg #(.BLOCK(BLOCK)) u_pg (
                .a      (a[gi*BLOCK +: BLOCK]),
                .b      (b[gi*BLOCK +: BLOCK]),
                .op_sub (op_sub),
                .gp     (blk_p[gi]),
                .gg     (blk_g[gi]),
                .sum0   (sum0_w[gi*BLOCK +: BLOCK]),
                .sum1   (sum1_w[gi*BLOCK +: BLOCK]),
                .msb_c0 (msb_c0_w[gi]),
                .msb_c1 (msb_c1_w[gi])
            );
            assign s_next[gi*BLOCK +: BLOCK] = carries[gi] ? sum1_reg[gi*BLOCK +: BLOCK]
                                                           : sum0_reg[gi*BLOCK +: BLOCK];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1_reg   <= 1'b0;
            p1_reg   <= '0;
            g1_reg   <= '0;
            sum0_reg <= '0;
            sum1_reg <= '0;
            cin1_reg <= 1'b0;
            msb0_reg <= 1'b0;
            msb1_reg <= 1'b0;
        end else if (adv1) begin
            v1_reg   <= in_valid;
            p1_reg   <= blk_p;
            g1_reg   <= blk_g;
            sum0_reg <= sum0_w;
            sum1_reg <= sum1_w;
            cin1_reg <= cin;
            msb0_reg <= msb_c0_w[NBLK-1];
            msb1_reg <= msb_c1_w[NBLK-1];
        end
    end

    // Blocks above NBLK contribute P=0/G=0 so the fixed-width lookahead stays exact.
    always_comb begin
        p_ext = '0;
        g_ext = '0;
        p_ext[NBLK-1:0] = p1_reg;
        g_ext[NBLK-1:0] = g1_reg;
    end

    assign carries   = cla_carries(p_ext, g_ext, cin1_reg);
    assign cout_next = carries[NBLK];
    assign c_msb     = carries[NBLK-1] ? msb1_reg : msb0_reg;
    assign ovf_next  = c_msb ^ cout_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v2_reg   <= 1'b0;
            s_reg    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (adv2) begin
            v2_reg   <= v1_reg;
            s_reg    <= s_next;
            cout_reg <= cout_next;
            ovf_reg  <= ovf_next;
            zero_reg <= ~|s_next;
        end
    end

    assign out_valid = v2_reg;
    assign s         = s_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

    // Only the top block's MSB terms and the low NBLK+1 carries feed the result.
    assign unused_bits = ^{msb_c0_w, msb_c1_w, carries};

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed vectors on a 32/8 instance plus a randomized sweep over four configurations.
module tb_cla_addsub_pipe;

    localparam int NCFG = 4;
    localparam int CW[NCFG] = '{32, 16, 64, 8};
    localparam int CB[NCFG] = '{8, 4, 8, 8};
    localparam int NBEATS = 10000;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        i_valid [NCFG];
    logic        o_iready[NCFG];
    logic [63:0] i_a     [NCFG];
    logic [63:0] i_b     [NCFG];
    logic        i_op    [NCFG];
    logic        i_cin   [NCFG];
    logic        o_valid [NCFG];
    logic        o_ready [NCFG];
    logic [63:0] o_s     [NCFG];
    logic        o_cout  [NCFG];
    logic        o_ovf   [NCFG];
    logic        o_zero  [NCFG];

    int   total = 0;
    int   bad = 0;
    res_t q [NCFG][$];
    int   out_cnt   [NCFG];
    logic stall_prev[NCFG];
    logic [67:0] held[NCFG];

    always #5 clock = ~clock;

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_dut
            localparam int W = CW[gi];
            localparam int B = CB[gi];
            logic [W-1:0] s_w;
            cla_addsub_pipe #(.WIDTH(W), .BLOCK(B)) u_dut (
                .clock     (clock),
                .reset_n   (reset_n),
                .in_valid  (i_valid[gi]),
                .in_ready  (o_iready[gi]),
                .a         (i_a[gi][W-1:0]),
                .b         (i_b[gi][W-1:0]),
                .op_sub    (i_op[gi]),
                .cin       (i_cin[gi]),
                .out_valid (o_valid[gi]),
                .out_ready (o_ready[gi]),
                .s         (s_w),
                .cout      (o_cout[gi]),
                .ovf       (o_ovf[gi]),
                .zero      (o_zero[gi])
            );
            assign o_s[gi] = 64'(s_w);
        end
    endgenerate

    // Reference: plain (W+1)-bit arithmetic; overflow from operand/result signs.
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic op, logic ci);
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bv;
        logic [64:0] full;
        res_t r;
        mask   = (65'd1 << w) - 65'd1;
        aa     = {1'b0, a} & mask;
        bv     = {1'b0, (op ? ~b : b)} & mask;
        full   = aa + bv + 65'(ci);
        r.s    = full[63:0] & mask[63:0];
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bv[w-1]) && (full[w-1] != aa[w-1]);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: one pass per instance on every falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < NCFG; i++) begin
            if (!reset_n) begin
                q[i].delete();
                stall_prev[i] = 1'b0;
            end else begin
                chk($sformatf("in_ready[%0d]", i), 68'(o_iready[i]),
                    68'(!(q[i].size() >= 2 && !o_ready[i])));
                if (stall_prev[i])
                    chk($sformatf("hold[%0d]", i),
                        {o_valid[i], o_s[i], o_cout[i], o_ovf[i], o_zero[i]}, held[i]);
                if (o_valid[i] && o_ready[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("spurious[%0d]", i), 68'(o_valid[i]), 68'd0);
                    end else begin
                        chk($sformatf("result[%0d]", i),
                            68'({o_s[i], o_cout[i], o_ovf[i], o_zero[i]}), 68'(q[i].pop_front()));
                        out_cnt[i]++;
                    end
                end
                if (i_valid[i] && o_iready[i])
                    q[i].push_back(model(CW[i], i_a[i], i_b[i], i_op[i], i_cin[i]));
                stall_prev[i] = o_valid[i] && !o_ready[i];
                held[i] = {o_valid[i], o_s[i], o_cout[i], o_ovf[i], o_zero[i]};
            end
        end
    end

    task automatic direct(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic ci, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
        @(posedge clock); #1;
        i_a[0] = 64'(a); i_b[0] = 64'(b); i_op[0] = op; i_cin[0] = ci; i_valid[0] = 1'b1;
        @(posedge clock); #1;
        i_valid[0] = 1'b0;
        chk({name, ".early"}, 68'(o_valid[0]), 68'd0);
        @(posedge clock); #1;
        chk({name, ".valid"}, 68'(o_valid[0]), 68'd1);
        chk({name, ".s"}, 68'(o_s[0]), 68'(es));
        chk({name, ".flags"}, 68'({o_cout[0], o_ovf[0], o_zero[0]}), 68'({ec, eo, ez}));
    endtask

    function automatic logic [63:0] pick(int w);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r = '0;
            2: r = 64'd1 << (w - 1);
            3: r = (64'd1 << (w - 1)) - 64'd1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic new_beat(input int i);
        i_a[i]   = pick(CW[i]);
        i_b[i]   = pick(CW[i]);
        i_op[i]  = 1'($urandom_range(0, 1));
        i_cin[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int   pat[10];
        int   sent, k, start, cyc;
        logic saw_block;
        int   sent_n[NCFG];
        int   start_n[NCFG];
        logic xfer[NCFG];
        logic [31:0] va, vb;
        res_t mr;

        pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
        reset_n = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            i_valid[i] = 1'b0; o_ready[i] = 1'b1;
            i_a[i] = '0; i_b[i] = '0; i_op[i] = 1'b0; i_cin[i] = 1'b0;
            out_cnt[i] = 0; stall_prev[i] = 1'b0; held[i] = '0;
        end

        // Model pinned against hand-computed values.
        mr = model(16, 64'h7FFF, 64'h1, 1'b0, 1'b0);
        chk("model.w16_ovf", 68'(mr), {64'h8000, 1'b0, 1'b1, 1'b0});
        mr = model(8, 64'h0, 64'h1, 1'b1, 1'b1);
        chk("model.w8_sub", 68'(mr), {64'hFF, 1'b0, 1'b0, 1'b0});
        mr = model(64, '1, 64'h1, 1'b0, 1'b0);
        chk("model.w64_wrap", 68'(mr), {64'h0, 1'b1, 1'b0, 1'b1});

        repeat (3) @(posedge clock);
        #1;
        chk("reset.out_valid", 68'(o_valid[0]), 68'd0);
        chk("reset.s", 68'(o_s[0]), 68'd0);
        chk("reset.flags", 68'({o_cout[0], o_ovf[0], o_zero[0]}), 68'd0);
        chk("reset.in_ready", 68'(o_iready[0]), 68'd1);
        reset_n = 1'b1;

        direct("add_wrap",   32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
        direct("add_ovf",    32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        direct("sub_ovf",    32'h80000000, 32'h1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        direct("sub_borrow", 32'h5,        32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        direct("sbb_chain",  32'h0,        32'h0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        direct("blk_carry",  32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        direct("mixed",      32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0, 1'b0);

        // Five back-to-back beats under a stalling consumer.
        @(posedge clock); #1;
        start = out_cnt[0]; saw_block = 1'b0; sent = 0; k = 0;
        va = 32'h0F0F0F0F; vb = 32'h3C3C3C3C;
        i_a[0] = 64'(va); i_b[0] = 64'(vb); i_op[0] = 1'b0; i_cin[0] = 1'b0;
        i_valid[0] = 1'b1; o_ready[0] = pat[0][0];
        while (sent < 5 && k < 50) begin
            @(negedge clock);
            if (!o_iready[0]) saw_block = 1'b1;
            if (i_valid[0] && o_iready[0]) sent++;
            @(posedge clock); #1;
            k++;
            o_ready[0] = (k < 10) ? pat[k][0] : 1'b1;
            if (sent < 5) begin
                i_a[0] = 64'(va + 32'h11111111 * 32'(sent));
                i_b[0] = 64'(vb ^ (32'hFF << (4 * sent)));
                i_op[0] = sent[0];
                i_cin[0] = sent[1];
            end else begin
                i_valid[0] = 1'b0;
            end
        end
        o_ready[0] = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        chk("bp.in_ready_dropped", 68'(saw_block), 68'd1);
        chk("bp.results", 68'(out_cnt[0] - start), 68'd5);

        // Reset with two beats in flight.
        o_ready[0] = 1'b0;
        i_a[0] = 64'h1; i_b[0] = 64'h2; i_op[0] = 1'b0; i_cin[0] = 1'b0; i_valid[0] = 1'b1;
        @(posedge clock); #1;
        i_a[0] = 64'h3;
        @(posedge clock); #1;
        i_valid[0] = 1'b0;
        reset_n = 1'b0;
        start = out_cnt[0];
        @(posedge clock); #1;
        reset_n = 1'b1;
        o_ready[0] = 1'b1;
        chk("rst_mid.out_valid", 68'(o_valid[0]), 68'd0);
        chk("rst_mid.s", 68'(o_s[0]), 68'd0);
        chk("rst_mid.in_ready", 68'(o_iready[0]), 68'd1);
        repeat (4) @(posedge clock);
        #1;
        chk("rst_mid.no_stale", 68'(out_cnt[0] - start), 68'd0);

        // Random sweep on all configurations in lockstep.
        for (int i = 0; i < NCFG; i++) begin
            sent_n[i] = 0; start_n[i] = out_cnt[i]; xfer[i] = 1'b0;
            new_beat(i);
            i_valid[i] = 1'b1;
            o_ready[i] = 1'($urandom_range(0, 1));
        end
        cyc = 0;
        while (cyc < 60000 && (sent_n[0] < NBEATS || sent_n[1] < NBEATS ||
                               sent_n[2] < NBEATS || sent_n[3] < NBEATS)) begin
            @(negedge clock);
            for (int i = 0; i < NCFG; i++) begin
                xfer[i] = i_valid[i] && o_iready[i];
                if (xfer[i]) sent_n[i]++;
            end
            @(posedge clock); #1;
            cyc++;
            for (int i = 0; i < NCFG; i++) begin
                o_ready[i] = ($urandom_range(0, 3) != 0);
                if (sent_n[i] >= NBEATS) begin
                    i_valid[i] = 1'b0;
                end else if (!i_valid[i] || xfer[i]) begin
                    new_beat(i);
                    i_valid[i] = ($urandom_range(0, 4) != 0);
                end
            end
        end
        for (int i = 0; i < NCFG; i++) begin
            i_valid[i] = 1'b0;
            o_ready[i] = 1'b1;
        end
        repeat (6) @(posedge clock);
        #1;
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("sweep.sent[%0d]", i), 68'(sent_n[i]), 68'(NBEATS));
            chk($sformatf("sweep.results[%0d]", i), 68'(out_cnt[i] - start_n[i]), 68'(NBEATS));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
